// File: rtl/note_tuning_ctrl.sv
// note_tuning_ctrl: converts note-on/note-off requests (MIDI 0..127) into the
// 32-bit phase-accumulator tuning word M, referenced to a 100 MHz clock.
// Notes played while the gate is held glide exponentially toward the new
// pitch.
//
// Ports:
//   clk          system clock (100 MHz)
//   rst_n        asynchronous active-low reset
//   note_valid   request valid; held by the requester until accepted
//   note_on      1 = note-on, 0 = note-off
//   note         MIDI note number (ignored for note-off)
//   note_ready   request accepted on an edge where note_valid & note_ready
//   tuning_word  oscillator M, 0 while the gate is closed
//   gate         note sounding
//   gliding      portamento in progress
module note_tuning_ctrl #(
  parameter int unsigned GLIDE_DIV   = 100000,
  parameter int unsigned GLIDE_SHIFT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        note_valid,
  input  logic        note_on,
  input  logic [6:0]  note,
  output logic        note_ready,
  output logic [31:0] tuning_word,
  output logic        gate,
  output logic        gliding
);

  typedef enum logic [1:0] {IDLE, DIVIDE, LOOKUP, GLIDE} state_t;

  localparam logic [19:0] DIV_LAST = 20'(GLIDE_DIV - 1);

  state_t        state_q, state_d;
  logic [6:0]    rem_q, rem_d;
  logic [3:0]    oct_q, oct_d;
  logic          legato_q, legato_d;
  logic [31:0]   current_q, current_d;
  logic [31:0]   target_q, target_d;
  logic [19:0]   cnt_q, cnt_d;
  logic          gate_q, gate_d;
  logic [31:0]   tw_q, tw_d;

  logic          accept;
  logic [31:0]   oct10_word;
  logic [31:0]   lut_word;
  logic signed [32:0] diff;
  logic signed [32:0] step;

  // Octave-10 tuning words: round(440 * 2^((51+k)/12) * 2^32 / 1e8).
  always_comb begin
    oct10_word = 32'd0;
    unique case (rem_q[3:0])
      4'd0:    oct10_word = 32'd359575;
      4'd1:    oct10_word = 32'd380957;
      4'd2:    oct10_word = 32'd403610;
      4'd3:    oct10_word = 32'd427610;
      4'd4:    oct10_word = 32'd453037;
      4'd5:    oct10_word = 32'd479976;
      4'd6:    oct10_word = 32'd508516;
      4'd7:    oct10_word = 32'd538754;
      4'd8:    oct10_word = 32'd570790;
      4'd9:    oct10_word = 32'd604731;
      4'd10:   oct10_word = 32'd640691;
      4'd11:   oct10_word = 32'd678788;
      default: oct10_word = 32'd0;
    endcase
  end

  assign lut_word = oct10_word >> (4'd10 - oct_q);

  assign note_ready = (state_q == IDLE) || (state_q == GLIDE);
  assign accept     = note_valid && note_ready;

  // Arithmetic shift floors toward -inf, so a falling glide keeps stepping by
  // at least -1 until it lands exactly; a rising one snaps once step hits 0.
  assign diff = $signed({1'b0, target_q}) - $signed({1'b0, current_q});
  assign step = diff >>> GLIDE_SHIFT;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    oct_d     = oct_q;
    legato_d  = legato_q;
    current_d = current_q;
    target_d  = target_q;
    cnt_d     = cnt_q;
    gate_d    = gate_q;

    unique case (state_q)
      IDLE, GLIDE: begin
        if (accept) begin
          if (note_on) begin
            rem_d    = note;
            oct_d    = '0;
            legato_d = gate_q;
            state_d  = DIVIDE;
          end else begin
            gate_d  = 1'b0;
            state_d = IDLE;
          end
        end else if (state_q == GLIDE) begin
          if (cnt_q == DIV_LAST) begin
            cnt_d = '0;
            if (step == '0) begin
              current_d = target_q;
              state_d   = IDLE;
            end else begin
              current_d = current_q + step[31:0];
            end
          end else begin
            cnt_d = cnt_q + 20'd1;
          end
        end
      end
      DIVIDE: begin
        if (rem_q >= 7'd12) begin
          rem_d = rem_q - 7'd12;
          oct_d = oct_q + 4'd1;
        end else begin
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        target_d = lut_word;
        if (!legato_q) begin
          current_d = lut_word;
          gate_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d   = '0;
          state_d = GLIDE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output word is registered from the next-state values so it lands on the
  // same edge as current/gate rather than one edge later.
  assign tw_d = gate_d ? current_d : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      oct_q     <= '0;
      legato_q  <= 1'b0;
      current_q <= '0;
      target_q  <= '0;
      cnt_q     <= '0;
      gate_q    <= 1'b0;
      tw_q      <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      oct_q     <= oct_d;
      legato_q  <= legato_d;
      current_q <= current_d;
      target_q  <= target_d;
      cnt_q     <= cnt_d;
      gate_q    <= gate_d;
      tw_q      <= tw_d;
    end
  end

  assign tuning_word = tw_q;
  assign gate        = gate_q;
  assign gliding     = (state_q == GLIDE);

endmodule

// File: tb/tb_note_tuning_ctrl.sv
// Self-checking bench for note_tuning_ctrl with a fast glide (GLIDE_DIV = 4,
// GLIDE_SHIFT = 3). Expected words come from the equal-temperament formula
// evaluated in real arithmetic; glide trajectories are the repeated
// (target - current) >>> shift recurrence, one step every GLIDE_DIV cycles.
module tb_note_tuning_ctrl;

  localparam int unsigned DIV = 4;
  localparam int unsigned SH  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        note_valid = 1'b0;
  logic        note_on = 1'b0;
  logic [6:0]  note = '0;
  logic        note_ready;
  logic [31:0] tuning_word;
  logic        gate;
  logic        gliding;

  int errors = 0;
  int checks = 0;

  longint m_cur  = 0;
  bit     m_gate = 1'b0;

  note_tuning_ctrl #(.GLIDE_DIV(DIV), .GLIDE_SHIFT(SH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .note_valid  (note_valid),
    .note_on     (note_on),
    .note        (note),
    .note_ready  (note_ready),
    .tuning_word (tuning_word),
    .gate        (gate),
    .gliding     (gliding)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  function automatic longint ref_word(int n);
    int  k = n % 12;
    int  o = n / 12;
    real f;
    f = 440.0 * (2.0 ** ((51.0 + k) / 12.0)) * 4294967296.0 / 1.0e8;
    return longint'($rtoi(f + 0.5)) >> (10 - o);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_tw"},    tuning_word, 0);
    chk({tag, "_gate"},  gate, 0);
    chk({tag, "_ready"}, note_ready, 1);
    chk({tag, "_glid"},  gliding, 0);
  endtask

  // Returns 1 ns after the accept edge.
  task automatic send(input bit on, input int n);
    int w = 0;
    @(negedge clk);
    while (!note_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_req", note_ready, 1);
    note_valid = 1'b1;
    note_on    = on;
    note       = 7'(n);
    @(posedge clk);
    #1;
    note_valid = 1'b0;
  endtask

  task automatic note_off();
    send(1'b0, $urandom_range(0, 127));
    chk("off_gate",  gate, 0);
    chk("off_tw",    tuning_word, 0);
    chk("off_glid",  gliding, 0);
    chk("off_ready", note_ready, 1);
    m_gate = 1'b0;
  endtask

  task automatic play_plain(input int n, input longint exp_word);
    int oct = n / 12;
    int lows = 0;
    send(1'b1, n);
    if (!note_ready) lows++;
    for (int e = 1; e <= oct + 1; e++) begin
      edge1();
      if (!note_ready) lows++;
      chk("plain_glid", gliding, 0);
    end
    chk("plain_tw_before", tuning_word, 0);
    chk("plain_ready_lows", lows, oct + 2);
    edge1();
    chk("plain_tw",    tuning_word, exp_word);
    chk("plain_gate",  gate, 1);
    chk("plain_ready", note_ready, 1);
    chk("plain_glid2", gliding, 0);
    m_cur  = exp_word;
    m_gate = 1'b1;
  endtask

  // Legato note; stop_after > 0 returns after that many glide ticks.
  task automatic glide(input int n, input int stop_after, input longint first_exp);
    longint t = ref_word(n);
    longint c = m_cur;
    longint s;
    longint q[$];
    int oct = n / 12;
    forever begin
      s = (t - c) >>> SH;
      if (s == 0) begin
        q.push_back(t);
        break;
      end
      c = c + s;
      q.push_back(c);
    end
    send(1'b1, n);
    repeat (oct + 1) edge1();
    chk("glide_pre_glid", gliding, 0);
    chk("glide_frozen",   tuning_word, m_cur);
    edge1();
    chk("glide_enter",    gliding, 1);
    chk("glide_enter_tw", tuning_word, m_cur);
    for (int k = 0; k < q.size(); k++) begin
      repeat (DIV) edge1();
      chk("glide_step", tuning_word, q[k]);
      if (k == 0 && first_exp >= 0) chk("glide_first", tuning_word, first_exp);
      chk("glide_flag", gliding, (k == q.size() - 1) ? 1'b0 : 1'b1);
      m_cur = q[k];
      if (stop_after != 0 && k + 1 == stop_after) break;
    end
  endtask

  initial begin
    int r;
    int n;

    // Reset
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_chk("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    edge1();
    reset_chk("rst_rel");

    // A4 from idle, then the table bounds
    play_plain(69, 18897);
    note_off();
    play_plain(127, 538754);
    note_off();
    play_plain(0, 351);
    note_off();

    // Rising legato glide A4 -> A5
    play_plain(69, 18897);
    glide(81, 0, 21259);
    chk("glide_final", tuning_word, 37795);
    chk("glide_final_ready", note_ready, 1);

    // Falling glide, retarget mid-glide, then note-off mid-glide
    glide(69, 5, -1);
    glide(60, 3, -1);
    note_off();
    play_plain(57, 9448);

    // Same-note re-trigger while held
    glide(57, 0, -1);
    chk("retrig_tw", tuning_word, 9448);

    // Asynchronous reset during DIVIDE
    send(1'b1, 127);
    repeat (3) edge1();
    #2 rst_n = 1'b0;
    #1 reset_chk("rst_div");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_cur = 0;
    m_gate = 1'b0;
    play_plain(69, 18897);

    // Asynchronous reset during GLIDE
    glide(81, 4, -1);
    chk("pre_rst_glid", gliding, 1);
    #2 rst_n = 1'b0;
    #1 reset_chk("rst_glide");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_cur = 0;
    m_gate = 1'b0;
    play_plain(69, 18897);

    // Random note-on/note-off sequence against the reference
    for (int i = 0; i < 25; i++) begin
      r = $urandom_range(0, 3);
      n = $urandom_range(0, 127);
      if (r == 0) note_off();
      else if (!m_gate) play_plain(n, ref_word(n));
      else glide(n, 0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
